// File: rtl/read_arb_pkg.sv
// Shared types and sizing helpers for the read job arbiter.
package read_arb_pkg;

   // Width of beat counts and engine length.
   localparam int unsigned LEN_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SETTLE,
      BUSY,
      DONE
   } arb_state_t;

   // Bits needed to encode a client index (at least one bit).
   function automatic int unsigned CLIENT_IDX_WIDTH(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // One extra bit so ptr + i cannot overflow before the wrap.
   logic [IW:0] cand;

   // Scan from ptr upward, wrapping at N; the first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (!any && req[cand[IW-1:0]]) begin
            any                  = 1'b1;
            grant[cand[IW-1:0]]  = 1'b1;
            idx                  = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/read_job_arbiter.sv
// Shares one read engine among several clients: round-robin job selection,
// engine launch, and steering of returned beats to the job owner.
module read_job_arbiter
   import read_arb_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 4,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [NUM_CLIENTS-1:0]           REQ_VALID,
   output logic [NUM_CLIENTS-1:0]           REQ_READY,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  REQ_LENGTH,
   output logic [NUM_CLIENTS-1:0]           RSP_VALID,
   output logic [DATA_WIDTH-1:0]            RSP_DATA,
   output logic                             RSP_LAST,
   output logic [NUM_CLIENTS-1:0]           JOB_DONE,
   output logic                             ERR_SPURIOUS,
   output logic                             ENG_READ_START,
   output logic [ADDR_WIDTH-1:0]            ENG_RADDR_START,
   output logic [LEN_WIDTH-1:0]             ENG_READ_LENGTH,
   input  logic                             ENG_RREQ_COUNT_DONE,
   input  logic                             ENG_RVALID_COPY,
   input  logic [DATA_WIDTH-1:0]            ENG_RDATA_COPY,
   input  logic                             ENG_RVALID_COUNT_DONE
);

   localparam int unsigned IW = CLIENT_IDX_WIDTH(NUM_CLIENTS);

   arb_state_t             state_q, state_d;
   logic [IW-1:0]          owner_q;
   logic [IW-1:0]          rr_ptr_q;
   logic [IW-1:0]          next_ptr;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   beat_q;
   logic                   err_q;

   logic [NUM_CLIENTS-1:0] pick_grant;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;
   logic [ADDR_WIDTH-1:0]  pick_addr;
   logic [LEN_WIDTH-1:0]   pick_len;
   logic [NUM_CLIENTS-1:0] owner_oh;

   logic accept;
   logic beat_fwd;
   logic spurious;

   rr_pick #(
      .N  (NUM_CLIENTS),
      .IW (IW)
   ) u_pick (
      .req   (REQ_VALID),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Select the winning client's address and length from the packed buses.
   always_comb begin
      pick_addr = '0;
      pick_len  = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (pick_grant[i]) begin
            pick_addr = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            pick_len  = REQ_LENGTH[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   // Handshake qualifiers and beat classification.
   always_comb begin
      // No handshake while reset is asserted, so nothing is accepted and lost.
      accept   = (state_q == IDLE) && pick_any && !RST;
      beat_fwd = ENG_RVALID_COPY && ((state_q == SETTLE) || (state_q == BUSY));
      spurious = ENG_RVALID_COPY &&
                 ((state_q == IDLE) || (state_q == START) || (state_q == DONE));
      next_ptr = (owner_q == IW'(NUM_CLIENTS - 1)) ? '0 : owner_q + IW'(1);
   end

   // Next-state logic; engine done flags are only trusted once in BUSY.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (pick_len != '0) ? START : DONE;
            end
         end
         START:  state_d = SETTLE;
         SETTLE: state_d = BUSY;
         BUSY: begin
            if (ENG_RVALID_COUNT_DONE && ENG_RREQ_COUNT_DONE) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output steering: beats and completion go only to the current owner.
   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
      REQ_READY         = accept ? pick_grant : '0;
      RSP_VALID         = beat_fwd ? owner_oh : '0;
      RSP_DATA          = beat_fwd ? ENG_RDATA_COPY : '0;
      RSP_LAST          = beat_fwd && (beat_q == (len_q - LEN_WIDTH'(1)));
      JOB_DONE          = (state_q == DONE) ? owner_oh : '0;
      ENG_READ_START    = (state_q == START);
      ENG_RADDR_START   = addr_q;
      ENG_READ_LENGTH   = len_q;
      ERR_SPURIOUS      = err_q;
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job latches and beat counter; the counter restarts with every new job.
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_q <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else if (accept) begin
         owner_q <= pick_idx;
         addr_q  <= pick_addr;
         len_q   <= pick_len;
         beat_q  <= '0;
      end else if (beat_fwd) begin
         beat_q  <= beat_q + LEN_WIDTH'(1);
      end
   end

   // Round-robin pointer advances past the owner on completion; error is sticky.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == DONE) begin
            rr_ptr_q <= next_ptr;
         end
         if (spurious) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_read_job_arbiter.sv
// Scoreboard bench for read_job_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_read_job_arbiter;

   localparam int NC = 4;
   localparam int DW = 64;
   localparam int AW = 32;

   logic CLK = 1'b0;
   logic RST;
   logic [NC-1:0]    REQ_VALID, REQ_READY, RSP_VALID, JOB_DONE;
   logic [NC*AW-1:0] REQ_ADDR;
   logic [NC*32-1:0] REQ_LENGTH;
   logic [DW-1:0]    RSP_DATA, ENG_RDATA_COPY;
   logic             RSP_LAST, ERR_SPURIOUS, ENG_READ_START;
   logic [AW-1:0]    ENG_RADDR_START;
   logic [31:0]      ENG_READ_LENGTH;
   logic             ENG_RREQ_COUNT_DONE, ENG_RVALID_COPY, ENG_RVALID_COUNT_DONE;

   read_job_arbiter #(
      .NUM_CLIENTS (NC),
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW)
   ) dut (
      .CLK                   (CLK),
      .RST                   (RST),
      .REQ_VALID             (REQ_VALID),
      .REQ_READY             (REQ_READY),
      .REQ_ADDR              (REQ_ADDR),
      .REQ_LENGTH            (REQ_LENGTH),
      .RSP_VALID             (RSP_VALID),
      .RSP_DATA              (RSP_DATA),
      .RSP_LAST              (RSP_LAST),
      .JOB_DONE              (JOB_DONE),
      .ERR_SPURIOUS          (ERR_SPURIOUS),
      .ENG_READ_START        (ENG_READ_START),
      .ENG_RADDR_START       (ENG_RADDR_START),
      .ENG_READ_LENGTH       (ENG_READ_LENGTH),
      .ENG_RREQ_COUNT_DONE   (ENG_RREQ_COUNT_DONE),
      .ENG_RVALID_COPY       (ENG_RVALID_COPY),
      .ENG_RDATA_COPY        (ENG_RDATA_COPY),
      .ENG_RVALID_COUNT_DONE (ENG_RVALID_COUNT_DONE)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          c;
      logic [63:0] d;
      logic        last;
   } beat_t;

   int          grant_q[$];
   logic [63:0] start_q[$];
   beat_t       beat_q[$];
   int          done_q[$];

   logic [63:0] mon_s;
   beat_t       mon_b;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] oh(input int c);
      return 64'(1) << c;
   endfunction

   // Monitor: every presented output event must match the head of its queue.
   always @(negedge CLK) begin
      if (!RST) begin
         if (REQ_READY != '0) begin
            if (grant_q.size() == 0) chk("unexpected_grant", 64'(REQ_READY), 64'(0));
            else chk("grant", 64'(REQ_READY), oh(grant_q.pop_front()));
         end
         if (ENG_READ_START) begin
            if (start_q.size() == 0) chk("unexpected_start", 64'(ENG_READ_START), 64'(0));
            else begin
               mon_s = start_q.pop_front();
               chk("start_addr", 64'(ENG_RADDR_START), 64'(mon_s[63:32]));
               chk("start_len", 64'(ENG_READ_LENGTH), 64'(mon_s[31:0]));
            end
         end
         if (RSP_VALID != '0) begin
            if (beat_q.size() == 0) chk("unexpected_rsp", 64'(RSP_VALID), 64'(0));
            else begin
               mon_b = beat_q.pop_front();
               chk("rsp_valid", 64'(RSP_VALID), oh(mon_b.c));
               chk("rsp_data", RSP_DATA, mon_b.d);
               chk("rsp_last", 64'(RSP_LAST), 64'(mon_b.last));
            end
         end
         if (JOB_DONE != '0) begin
            if (done_q.size() == 0) chk("unexpected_done", 64'(JOB_DONE), 64'(0));
            else chk("job_done", 64'(JOB_DONE), oh(done_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_zero(input string name);
      @(negedge CLK);
      chk({name, "_req_ready"}, 64'(REQ_READY), 64'(0));
      chk({name, "_rsp_valid"}, 64'(RSP_VALID), 64'(0));
      chk({name, "_rsp_data"}, RSP_DATA, 64'(0));
      chk({name, "_rsp_last"}, 64'(RSP_LAST), 64'(0));
      chk({name, "_job_done"}, 64'(JOB_DONE), 64'(0));
      chk({name, "_err"}, 64'(ERR_SPURIOUS), 64'(0));
      chk({name, "_eng_start"}, 64'(ENG_READ_START), 64'(0));
      chk({name, "_eng_addr"}, 64'(ENG_RADDR_START), 64'(0));
      chk({name, "_eng_len"}, 64'(ENG_READ_LENGTH), 64'(0));
   endtask

   // Runs one job from an IDLE cycle; returns at the next IDLE cycle.
   task automatic job(input int c, input logic [31:0] addr, input logic [31:0] len,
                      input bit stale, input logic [3:0] vmask, input bit hold);
      logic [63:0] d;
      REQ_VALID                = vmask;
      REQ_ADDR[c*32 +: 32]     = addr;
      REQ_LENGTH[c*32 +: 32]   = len;
      ENG_RREQ_COUNT_DONE      = stale;
      ENG_RVALID_COUNT_DONE    = stale;
      grant_q.push_back(c);
      if (len == 0) begin
         done_q.push_back(c);
         step();
         if (!hold) REQ_VALID = '0;
         @(negedge CLK);
         chk("zero_len_done_cycle1", 64'(JOB_DONE), oh(c));
         chk("zero_len_no_start", 64'(ENG_READ_START), 64'(0));
         step();
      end else begin
         start_q.push_back({addr, len});
         step();
         if (!hold) REQ_VALID = '0;
         @(negedge CLK);
         chk("start_cycle1", 64'(ENG_READ_START), 64'(1));
         step();
         step();
         ENG_RREQ_COUNT_DONE   = 1'b0;
         ENG_RVALID_COUNT_DONE = 1'b0;
         for (int k = 0; k < int'(len); k++) begin
            d = {addr, 32'(k)} ^ 64'h5A5A_0000_0000_C3C3;
            ENG_RVALID_COPY = 1'b1;
            ENG_RDATA_COPY  = d;
            beat_q.push_back('{c, d, (k == int'(len) - 1)});
            step();
         end
         ENG_RVALID_COPY       = 1'b0;
         ENG_RDATA_COPY        = '0;
         ENG_RREQ_COUNT_DONE   = 1'b1;
         ENG_RVALID_COUNT_DONE = 1'b1;
         done_q.push_back(c);
         @(negedge CLK);
         chk("no_early_done", 64'(JOB_DONE), 64'(0));
         step();
         ENG_RREQ_COUNT_DONE   = 1'b0;
         ENG_RVALID_COUNT_DONE = 1'b0;
         @(negedge CLK);
         chk("done_timing", 64'(JOB_DONE), oh(c));
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST                   = 1'b1;
      REQ_VALID             = '0;
      REQ_ADDR              = '0;
      REQ_LENGTH            = '0;
      ENG_RREQ_COUNT_DONE   = 1'b0;
      ENG_RVALID_COPY       = 1'b0;
      ENG_RDATA_COPY        = '0;
      ENG_RVALID_COUNT_DONE = 1'b0;
      step();
      step();
      RST = 1'b0;
      check_zero("reset");
      step();

      // Fairness: all four hold requests, len 2, grants 0,1,2,3,0.
      for (int i = 0; i < NC; i++) begin
         REQ_ADDR[i*32 +: 32]   = 32'h1000 + 32'(i * 16);
         REQ_LENGTH[i*32 +: 32] = 32'd2;
      end
      for (int n = 0; n < 5; n++) begin
         job(n % NC, 32'h1000 + 32'((n % NC) * 16), 32'd2, 1'b0, 4'b1111, 1'b1);
      end
      REQ_VALID = '0;

      // Single job on client 1.
      job(1, 32'h100, 32'd4, 1'b0, 4'b0010, 1'b0);
      @(negedge CLK);
      chk("err_clear", 64'(ERR_SPURIOUS), 64'(0));
      step();

      // Zero-length job on client 2.
      job(2, 32'h200, 32'd0, 1'b0, 4'b0100, 1'b0);

      // Engine done flags stale-high through START/SETTLE.
      job(0, 32'h300, 32'd3, 1'b1, 4'b0001, 1'b0);

      // Spurious beat in IDLE.
      ENG_RVALID_COPY = 1'b1;
      ENG_RDATA_COPY  = 64'h0BAD;
      @(negedge CLK);
      chk("spurious_no_rsp", 64'(RSP_VALID), 64'(0));
      chk("err_not_yet", 64'(ERR_SPURIOUS), 64'(0));
      step();
      ENG_RVALID_COPY = 1'b0;
      ENG_RDATA_COPY  = '0;
      @(negedge CLK);
      chk("err_set", 64'(ERR_SPURIOUS), 64'(1));
      step();
      job(3, 32'h400, 32'd0, 1'b0, 4'b1000, 1'b0);
      @(negedge CLK);
      chk("err_sticky", 64'(ERR_SPURIOUS), 64'(1));
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      @(negedge CLK);
      chk("err_cleared_by_rst", 64'(ERR_SPURIOUS), 64'(0));
      step();

      // Move rr_ptr to 2, then reset in the middle of client 2's 8-beat job.
      job(1, 32'h500, 32'd1, 1'b0, 4'b0010, 1'b0);
      REQ_VALID               = 4'b0100;
      REQ_ADDR[2*32 +: 32]    = 32'h600;
      REQ_LENGTH[2*32 +: 32]  = 32'd8;
      grant_q.push_back(2);
      start_q.push_back({32'h600, 32'd8});
      step();
      REQ_VALID = '0;
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         ENG_RVALID_COPY = 1'b1;
         ENG_RDATA_COPY  = 64'hF00D_0000 + 64'(k);
         beat_q.push_back('{2, 64'hF00D_0000 + 64'(k), 1'b0});
         step();
      end
      ENG_RVALID_COPY = 1'b0;
      ENG_RDATA_COPY  = '0;
      RST             = 1'b1;
      step();
      RST = 1'b0;
      check_zero("mid_reset");
      step();
      step();

      // Pointer must be back at 0: clients 1 and 3 request, 1 wins.
      job(1, 32'h700, 32'd1, 1'b0, 4'b1010, 1'b0);
      step();
      step();

      chk("grant_q_drained", 64'(grant_q.size()), 64'(0));
      chk("start_q_drained", 64'(start_q.size()), 64'(0));
      chk("beat_q_drained", 64'(beat_q.size()), 64'(0));
      chk("done_q_drained", 64'(done_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
